// File: rtl/byte_bus_responder.sv
// Target side of the byte-serial CPU bus: collects address, write data and a
// command byte over five cycles, runs one word access, streams read data back.
module byte_bus_responder #(
  parameter int unsigned TURNAROUND = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  addr_in,
  input  logic [7:0]  wdata_in,
  output logic [7:0]  rdata_out,
  output logic        rdata_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_WAIT,
    S_RDATA,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                discard_q, discard_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BYTE_W-1:0]   rdata_out_q, rdata_out_d;
  logic                rdata_oe_q, rdata_oe_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                ack_c;

  // An acknowledge only counts while a request is outstanding.
  assign ack_c = mem_ack & mem_req_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_out_d = '0;
    rdata_oe_d  = 1'b0;
    err_d       = err_q;

    if (ack_c) begin
      mem_req_d = 1'b0;
      if (!we_q && !discard_q) begin
        rdata_d = mem_rdata;
      end
    end

    if (start && busy_q) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          addr_d[7:0]  = addr_in;
          wdata_d[7:0] = wdata_in;
          idx_d        = 2'd1;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        addr_d[{idx_q, 3'b000} +: BYTE_W]  = addr_in;
        wdata_d[{idx_q, 3'b000} +: BYTE_W] = wdata_in;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        we_d        = addr_in[0];
        mem_we_d    = addr_in[0];
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
        mem_req_d   = 1'b1;
        rdata_d     = '0;
        discard_d   = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(TURNAROUND - 1)) begin
          // No ack by the last turnaround cycle: flag it and return zeros.
          if (mem_req_q && !mem_ack) begin
            err_d     = 1'b1;
            discard_d = 1'b1;
            rdata_d   = '0;
          end
          idx_d   = 2'd0;
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDATA: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = mem_req_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!mem_req_d) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte lane is driven one cycle ahead so the registered output lines up.
    if (state_d == S_RDATA && !we_d) begin
      rdata_out_d = rdata_d[{idx_d, 3'b000} +: BYTE_W];
      rdata_oe_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE) || mem_req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_out_q <= '0;
      rdata_oe_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_out_q <= rdata_out_d;
      rdata_oe_q  <= rdata_oe_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign rdata_out = rdata_out_q;
  assign rdata_oe  = rdata_oe_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_byte_bus_responder.sv
// Directed bench for byte_bus_responder: writes, reads, timeout, drain,
// mid-frame start, mid-frame reset and back-to-back frames.
module tb_byte_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  addr_in = 8'h00;
  logic [7:0]  wdata_in = 8'h00;
  logic [7:0]  rdata_out;
  logic        rdata_oe;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  byte_bus_responder #(.TURNAROUND(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_in(addr_in),
    .wdata_in(wdata_in), .rdata_out(rdata_out), .rdata_oe(rdata_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called inside T0; returns inside T4 with the command byte on the lane.
  task automatic send_header(input logic [31:0] a, input logic [31:0] w,
                             input logic [7:0] cmd, input int extra);
    for (int i = 0; i < 4; i++) begin
      start    = (i == 0) || (i == extra);
      addr_in  = a[8*i +: 8];
      wdata_in = w[8*i +: 8];
      step();
    end
    start    = 1'b0;
    addr_in  = cmd;
    wdata_in = 8'hA5;
  endtask

  // Read frame from T0 through T11 with ack at ack_t (ack_t <= 10).
  task automatic run_read(input logic [31:0] a, input int ack_t,
                          input logic [31:0] data, input logic [31:0] exp_word,
                          input logic exp_err, input string nm);
    logic [7:0] eb;
    logic       eoe;
    logic       ereq;
    logic       ebusy;
    send_header(a, 32'h0, 8'h00, -1);
    for (int t = 5; t <= 11; t++) begin
      step();
      mem_ack   = (t == ack_t);
      mem_rdata = data;
      ereq  = (t <= ack_t);
      eoe   = (t >= 7) && (t <= 10);
      eb    = eoe ? exp_word[8*(t-7) +: 8] : 8'h00;
      ebusy = (ack_t >= 10);
      n_checks++;
      if ({rdata_out, rdata_oe, mem_req} !== {eb, eoe, ereq}) begin
        n_fail++;
        $display("FAIL %s lanes T%0d: got out=%h oe=%b req=%b, want out=%h oe=%b req=%b",
                 nm, t, rdata_out, rdata_oe, mem_req, eb, eoe, ereq);
      end
      if (ereq) begin
        n_checks++;
        if ({mem_we, mem_addr} !== {1'b0, a}) begin
          n_fail++;
          $display("FAIL %s req T%0d: got we=%b addr=%h, want we=0 addr=%h",
                   nm, t, mem_we, mem_addr, a);
        end
      end
      if (t >= 7) begin
        n_checks++;
        if (err !== exp_err) begin
          n_fail++;
          $display("FAIL %s err T%0d: got %b want %b", nm, t, err, exp_err);
        end
      end
      if (t == 11) begin
        n_checks++;
        if (busy !== ebusy) begin
          n_fail++;
          $display("FAIL %s busy T11: got %b want %b", nm, busy, ebusy);
        end
      end
    end
    mem_ack = 1'b0;
    if (ack_t >= 10) begin
      step();
      n_checks++;
      if ({busy, mem_req, rdata_oe} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s drain T12: got busy=%b req=%b oe=%b want 000", nm, busy, mem_req, rdata_oe);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({rdata_out, rdata_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, err} !== 79'h0) begin
      n_fail++;
      $display("FAIL reset_values: got out=%h oe=%b req=%b we=%b addr=%h wdata=%h busy=%b err=%b want all 0",
               rdata_out, rdata_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    send_header(32'h12345678, 32'hDEADBEEF, 8'h01, -1);
    step();
    mem_ack = 1'b1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, busy, rdata_oe} !== {1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL write_T5: got req=%b we=%b addr=%h wdata=%h busy=%b oe=%b want 1 1 12345678 deadbeef 1 0",
               mem_req, mem_we, mem_addr, mem_wdata, busy, rdata_oe);
    end
    for (int t = 6; t <= 10; t++) begin
      step();
      mem_ack = 1'b0;
      n_checks++;
      if ({mem_req, rdata_oe, rdata_out, busy, err} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL write_T%0d: got req=%b oe=%b out=%h busy=%b err=%b want 0 0 00 1 0",
                 t, mem_req, rdata_oe, rdata_out, busy, err);
      end
    end
    step();
    n_checks++;
    if ({busy, err, rdata_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL write_T11: got busy=%b err=%b oe=%b want 000", busy, err, rdata_oe);
    end
  endtask

  task automatic test_read();
    run_read(32'h00001000, 6, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "read");
  endtask

  task automatic test_start_mid();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_mid_pre_err: got %b want 0", err);
    end
    send_header(32'h89ABCDEF, 32'h01234567, 8'hFF, 2);
    n_checks++;
    if ({err, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_mid_err: got err=%b busy=%b want 1 1", err, busy);
    end
    step();
    mem_ack = 1'b1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h89ABCDEF, 32'h01234567}) begin
      n_fail++;
      $display("FAIL start_mid_req: got req=%b we=%b addr=%h wdata=%h want 1 1 89abcdef 01234567",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    for (int t = 6; t <= 11; t++) begin
      step();
      mem_ack = 1'b0;
    end
    n_checks++;
    if ({busy, mem_req, rdata_oe, err} !== 4'b0001) begin
      n_fail++;
      $display("FAIL start_mid_end: got busy=%b req=%b oe=%b err=%b want 0 0 0 1",
               busy, mem_req, rdata_oe, err);
    end
  endtask

  task automatic test_timeout();
    run_read(32'h00002000, 9, 32'h12345678, 32'h00000000, 1'b1, "timeout");
  endtask

  task automatic test_drain();
    run_read(32'h00003000, 10, 32'h87654321, 32'h00000000, 1'b1, "drain");
  endtask

  task automatic test_reset_mid();
    start    = 1'b1;
    addr_in  = 8'h44;
    wdata_in = 8'h00;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if ({busy, err} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got busy=%b err=%b want 1 1", busy, err);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rdata_out, rdata_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, err} !== 79'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got req=%b busy=%b err=%b addr=%h want all 0",
               mem_req, busy, err, mem_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    run_read(32'h00004000, 5, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    n_checks++;
    if ({busy, mem_req, rdata_oe, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stray_ack: got busy=%b req=%b oe=%b err=%b want 0000", busy, mem_req, rdata_oe, err);
    end
    step();
    run_read(32'h00005000, 6, 32'h11223344, 32'h11223344, 1'b0, "b2b_first");
    run_read(32'h00006000, 5, 32'h55667788, 32'h55667788, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_start_mid();
    test_timeout();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
